// File: rtl/data_sram_responder_pkg.sv
// Shared types for the data-SRAM request path: the queued request entry,
// the service-engine states and the byte-strobe merge helper.
package sram_if_pkg;

  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_IDX_W  = 30;
  localparam int SRAM_CNT_W  = 4;

  typedef struct packed {
    logic                   wr;
    logic [3:0]             wstrb;
    logic [SRAM_IDX_W-1:0]  idx;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

  typedef enum logic {S_IDLE, S_BUSY} sram_state_t;

  function automatic logic [SRAM_DATA_W-1:0] mergeBytes(
    input logic [SRAM_DATA_W-1:0] oldWord,
    input logic [SRAM_DATA_W-1:0] newWord,
    input logic [3:0]             strb
  );
    logic [SRAM_DATA_W-1:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (oldWord & ~mask) | (newWord & mask);
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Request/response bundle between the execute stage (master) and the
// data-SRAM responder (slave).
interface data_sram_if;
  import sram_if_pkg::*;

  logic                   req;
  logic                   wr;
  logic [3:0]             wstrb;
  logic [31:0]            addr;
  logic [SRAM_DATA_W-1:0] wdata;
  logic                   addr_ok;
  logic                   data_ok;
  logic [SRAM_DATA_W-1:0] rdata;

  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/data_sram_responder_fifo.sv
// In-order request queue for the responder; DEPTH need not be a power of two,
// so the pointers wrap explicitly.
module sram_req_fifo
  import sram_if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  sram_req_t             i_data,
  input  logic                  i_pop,
  output sram_req_t             o_head,
  output logic [SRAM_CNT_W-1:0] o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sram_req_t             r_slots [DEPTH];
  logic [PTR_W-1:0]      r_rdPtr;
  logic [PTR_W-1:0]      r_wrPtr;
  logic [SRAM_CNT_W-1:0] r_count;
  logic                  w_doPush;
  logic                  w_doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_doPush) r_slots[r_wrPtr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      if (w_doPush && !w_doPop)      r_count <= r_count + SRAM_CNT_W'(1);
      else if (w_doPop && !w_doPush) r_count <= r_count - SRAM_CNT_W'(1);
    end
  end

  assign o_head  = r_slots[r_rdPtr];
  assign o_count = r_count;
  assign o_full  = (r_count == SRAM_CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: queues execute-stage requests in order and answers each
// one after a fixed wait-state latency against a byte-strobed word array.
module data_sram_responder
  import sram_if_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 2
) (
  input logic        clk,
  input logic        reset,
  data_sram_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  sram_state_t            r_state;
  logic [3:0]             r_cnt;
  logic [SRAM_DATA_W-1:0] r_mem [2**ADDR_WIDTH];

  sram_req_t             w_entry;
  sram_req_t             w_head;
  logic [SRAM_CNT_W-1:0] w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_dataOk;
  logic [ADDR_WIDTH-1:0] w_headIdx;
  logic                  w_unusedBits;

  // No pass-through: a pop in this cycle does not free a slot until the next.
  assign bus.addr_ok = !reset && !w_full;
  assign w_push      = bus.req && bus.addr_ok;

  always_comb begin
    w_entry       = '0;
    w_entry.wr    = bus.wr;
    w_entry.wstrb = bus.wstrb;
    w_entry.idx   = SRAM_IDX_W'(bus.addr[ADDR_WIDTH+1:2]);
    w_entry.wdata = bus.wdata;
  end

  sram_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_dataOk),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_dataOk     = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_headIdx    = w_head.idx[ADDR_WIDTH-1:0];
  assign bus.data_ok  = w_dataOk;
  assign bus.rdata    = (w_dataOk && !w_head.wr) ? r_mem[w_headIdx] : '0;
  assign w_unusedBits = ^{bus.addr[1:0], bus.addr[31:ADDR_WIDTH+2],
                          w_head.idx[SRAM_IDX_W-1:ADDR_WIDTH], w_empty};

  // The array is deliberately never reset; only queued work is discarded.
  always_ff @(posedge clk) begin
    if (w_dataOk && w_head.wr)
      r_mem[w_headIdx] <= mergeBytes(r_mem[w_headIdx], w_head.wdata, w_head.wstrb);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0)
            r_cnt <= r_cnt - 4'd1;
          else if (w_count > SRAM_CNT_W'(1) || w_push)
            r_cnt <= CNT_LOAD;
          else
            r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances with different latency/depth,
// a hand-derived vector table, directed bursts and a randomized phase checked
// against a queue-based reference model.
module tb_data_sram_responder;

  localparam int NDUT = 3;
  localparam int AW   = 10;
  localparam int MAXQ = 8;

  typedef struct {
    bit          rst;
    bit          req;
    bit          wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          expAddrOk;
    bit          expDataOk;
    logic [31:0] expRdata;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [3:0]  strb;
    int          idx;
    logic [31:0] data;
    longint      resp;
  } expOp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tReq   [NDUT];
  logic        tWr    [NDUT];
  logic [3:0]  tStrb  [NDUT];
  logic [31:0] tAddr  [NDUT];
  logic [31:0] tWdata [NDUT];
  logic        oAddrOk[NDUT];
  logic        oDataOk[NDUT];
  logic [31:0] oRdata [NDUT];

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  // Reference model: per instance, a list of outstanding ops with the cycle
  // each one must complete in, plus a shadow copy of the word array.
  expOp_t      mq     [NDUT][MAXQ];
  int          mCount [NDUT];
  longint      mTail  [NDUT];
  logic [31:0] mMem   [NDUT][1 << AW];
  bit          mKnown [NDUT][1 << AW];

  vec_t vecs[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    data_sram_if bus ();

    data_sram_responder #(
      .ADDR_WIDTH  (AW),
      .LATENCY     (g == 0 ? 2 : (g == 1 ? 3 : 1)),
      .QUEUE_DEPTH (g == 2 ? 3 : 2)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign bus.req    = tReq[g];
    assign bus.wr     = tWr[g];
    assign bus.wstrb  = tStrb[g];
    assign bus.addr   = tAddr[g];
    assign bus.wdata  = tWdata[g];
    assign oAddrOk[g] = bus.addr_ok;
    assign oDataOk[g] = bus.data_ok;
    assign oRdata[g]  = bus.rdata;
  end

  function automatic int latOf(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 3 : 1);
  endfunction

  function automatic int depOf(input int d);
    return (d == 2) ? 3 : 2;
  endfunction

  function automatic logic [31:0] patWord(input int d, input int idx);
    return 32'hC0DE_0000 ^ 32'(d << 24) ^ 32'(idx * 32'h0001_0203);
  endfunction

  function automatic vec_t mkVec(input bit rst, input bit req, input bit wr,
                                 input logic [3:0] strb, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit aok,
                                 input bit dok, input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.req = req; v.wr = wr; v.strb = strb; v.addr = addr;
    v.wdata = wdata; v.expAddrOk = aok; v.expDataOk = dok; v.expRdata = rd;
    return v;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, d, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input int d, input logic req, input logic wr,
                               input logic [3:0] strb, input logic [31:0] addr,
                               input logic [31:0] wdata);
    tReq[d]   = req;
    tWr[d]    = wr;
    tStrb[d]  = strb;
    tAddr[d]  = addr;
    tWdata[d] = wdata;
  endtask

  // Compares every instance against the model for the current cycle, then
  // advances the model across the coming clock edge.
  task automatic checkOutput();
    for (int d = 0; d < NDUT; d++) begin
      bit          eAok;
      bit          eDok;
      bit          rdKnown;
      logic [31:0] eRd;
      expOp_t      op;
      eAok    = !reset && (mCount[d] < depOf(d));
      eDok    = !reset && (mCount[d] > 0) && (mq[d][0].resp == cyc);
      eRd     = 32'h0;
      rdKnown = 1'b1;
      if (eDok && !mq[d][0].wr) begin
        eRd     = mMem[d][mq[d][0].idx];
        rdKnown = mKnown[d][mq[d][0].idx];
      end
      check("addr_ok", d, 32'(oAddrOk[d]), 32'(eAok));
      check("data_ok", d, 32'(oDataOk[d]), 32'(eDok));
      if (rdKnown) check("rdata", d, oRdata[d], eRd);

      if (reset) begin
        mCount[d] = 0;
        mTail[d]  = -100;
      end else begin
        if (eDok) begin
          op = mq[d][0];
          if (op.wr) begin
            for (int b = 0; b < 4; b++)
              if (op.strb[b]) mMem[d][op.idx][8*b +: 8] = op.data[8*b +: 8];
            if (op.strb == 4'hF) mKnown[d][op.idx] = 1'b1;
          end
          for (int k = 1; k < mCount[d]; k++) mq[d][k-1] = mq[d][k];
          mCount[d]--;
        end
        if (tReq[d] && eAok) begin
          op.wr   = tWr[d];
          op.strb = tStrb[d];
          op.idx  = int'(tAddr[d][AW+1:2]);
          op.data = tWdata[d];
          op.resp = ((cyc > mTail[d]) ? cyc : mTail[d]) + latOf(d);
          mTail[d] = op.resp;
          mq[d][mCount[d]] = op;
          mCount[d]++;
        end
      end
    end
  endtask

  task automatic stepCycle();
    #1;
    checkOutput();
    @(negedge clk);
    cyc++;
  endtask

  task automatic runVector(input vec_t v);
    reset = v.rst;
    applyStimulus(0, v.req, v.wr, v.strb, v.addr, v.wdata);
    #1;
    check("vecAddrOk", 0, 32'(oAddrOk[0]), 32'(v.expAddrOk));
    check("vecDataOk", 0, 32'(oDataOk[0]), 32'(v.expDataOk));
    check("vecRdata", 0, oRdata[0], v.expRdata);
    checkOutput();
    @(negedge clk);
    cyc++;
  endtask

  // Holds req high for n consecutive word ops, stepping to the next op only
  // when one is accepted; checks response spacing and in-order read data.
  task automatic streamOps(input int d, input int n, input bit isWr, input int baseIdx);
    int     issued;
    int     done;
    int     budget;
    longint firstAccept;
    longint lastPulse;
    issued = 0; done = 0; budget = 0; firstAccept = -1; lastPulse = -1;
    while (done < n && budget < 200) begin
      if (issued < n)
        applyStimulus(d, 1'b1, isWr, 4'hF, 32'((baseIdx + issued) << 2),
                      patWord(d, baseIdx + issued));
      else
        applyStimulus(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      if (oDataOk[d]) begin
        if (lastPulse >= 0)
          check("pulseGap", d, 32'(cyc - lastPulse), 32'(latOf(d)));
        else
          check("firstLatency", d, 32'(cyc - firstAccept), 32'(latOf(d)));
        if (!isWr) check("burstData", d, oRdata[d], patWord(d, baseIdx + done));
        lastPulse = cyc;
        done++;
      end
      if (tReq[d] && oAddrOk[d]) begin
        if (firstAccept < 0) firstAccept = cyc;
        issued++;
      end
      checkOutput();
      @(negedge clk);
      cyc++;
      budget++;
    end
    check("burstDone", d, 32'(done), 32'(n));
    applyStimulus(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  rStrb;
    logic [31:0] rAddr;
    int          rIdx;

    for (int d = 0; d < NDUT; d++) begin
      applyStimulus(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      mCount[d] = 0;
      mTail[d]  = -100;
    end

    // Hand-derived cycle table for instance 0 (LATENCY=2, QUEUE_DEPTH=2).
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b1, 1'b1, 1'b0, 4'h0, 32'h40,   32'h0,        1'b0, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 4'hF, 32'h40,   32'hDEADBEEF, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 4'h0, 32'h40,   32'h0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b1, 32'hDEADBEEF));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 4'h5, 32'h40,   32'h11223344, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 4'h0, 32'h40,   32'h0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 4'h0, 32'h40,   32'hFFFFFFFF, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 4'h0, 32'h40,   32'hFFFFFFFF, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'hDE22BE44));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 4'h0, 32'h1043, 32'h0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b1, 32'hDE22BE44));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 4'hF, 32'h40,   32'h0BADF00D, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 4'h0, 32'h40,   32'h0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 4'h0, 32'h40,   32'h0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b1, 32'hDE22BE44));

    @(negedge clk);
    $display("[TB] vector table: %0d cycles on dut0", vecs.size());
    foreach (vecs[i]) runVector(vecs[i]);
    reset = 1'b0;

    $display("[TB] full-queue burst on dut1, streaming burst on dut2");
    streamOps(1, 4, 1'b1, 0);
    streamOps(1, 4, 1'b0, 0);
    streamOps(2, 8, 1'b1, 100);
    streamOps(2, 8, 1'b0, 100);

    for (int d = 0; d < NDUT; d++) streamOps(d, 8, 1'b1, 32);

    $display("[TB] randomized phase");
    for (int c = 0; c < 900; c++) begin
      reset = ($urandom_range(0, 249) == 0);
      for (int d = 0; d < NDUT; d++) begin
        rIdx  = 32 + $urandom_range(0, 7);
        rStrb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        rAddr = {20'($urandom), 10'(rIdx), 2'($urandom_range(0, 3))};
        applyStimulus(d, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                      rStrb, rAddr, $urandom);
      end
      stepCycle();
    end

    reset = 1'b0;
    for (int d = 0; d < NDUT; d++) applyStimulus(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int c = 0; c < 40; c++) stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Responder end of the data-SRAM request interface driven by the execute stage. It accepts read and write requests over a `req`/`addr_ok` handshake and queues them in order. Each request is serviced after a programmable wait-state latency against an internal word-organised array with byte strobes, and is completed by a one-cycle `data_ok` pulse carrying `rdata`. It is used as the data-memory model in the CPU bench and as the reference responder for the load/store path.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-index width; the array holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: cycles from acceptance to `data_ok` when the engine is idle; legal range is 1..15.
- `QUEUE_DEPTH`, default 2: maximum number of outstanding accepted requests, including the one in service; legal range is 1..8.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  request valid.
- `wr`  in  1  1 = write, 0 = read.
- `wstrb`  in  4  byte enables for writes; bit i enables `wdata[8i+7:8i]`.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data.
- `addr_ok`  out  1  request accepted this cycle when `req && addr_ok`.
- `data_ok`  out  1  one-cycle completion pulse for the oldest outstanding request.
- `rdata`  out  32  read data, valid while `data_ok` is high.

## Operation
- Accept rule: `addr_ok = !reset && (count < QUEUE_DEPTH)`, where `count` is the occupancy at the start of the cycle.
  - A pop in the same cycle does not raise `addr_ok`; there is no pass-through.
- An accepted request pushes `{wr, wstrb, word index = addr[ADDR_WIDTH+1:2], wdata}` into an in-order FIFO.
  - `addr[1:0]` and `addr[31:ADDR_WIDTH+2]` are ignored.
- Service FSM, two states:
  - IDLE: no request in service. On an acceptance edge with `count == 0`, go to BUSY and load `cnt <= LATENCY-1`.
  - BUSY, `cnt != 0`: `cnt <= cnt - 1`.
  - BUSY, `cnt == 0`: perform the head operation, assert `data_ok`, and pop the head.
    - If another entry remains, or is pushed this cycle, stay in BUSY with `cnt <= LATENCY-1`.
    - Otherwise go to IDLE.
- Read completion: `rdata` = array word at the head index, sampled in the `data_ok` cycle.
- Write completion: the enabled bytes of the array word are updated at the `data_ok` edge, and `rdata` = 0.
  - `wstrb == 0` changes nothing but still produces `data_ok`.
- Responses are strictly in acceptance order. A read queued behind a write to the same word returns the written data.
- Push and pop in the same cycle: occupancy is unchanged and both take effect.
- Reset, asserted at any time:
  - FIFO is emptied, FSM goes to IDLE, `cnt` = 0.
  - Outstanding requests are dropped and no `data_ok` is issued for them.
  - Array contents are not cleared.
- Reset values: `addr_ok` = 0 (it rises in the first cycle after deassertion), `data_ok` = 0, `rdata` = 0.

## Timing
- Request accepted in cycle k with the engine idle: `data_ok` is high in cycle k+LATENCY.
- Queued requests: each `data_ok` is exactly LATENCY cycles after the preceding `data_ok`.
- Peak throughput is one response per LATENCY cycles. With LATENCY=1 that is back-to-back `data_ok`.
- `data_ok` is never high for more than one cycle per request.
- `data_ok` and `rdata` are functions of registered state only, with no combinational path from `req`.
- `addr_ok` depends only on `reset` and registered occupancy.

## Structure
- Shared package `sram_if_pkg` holds:
  - the request entry struct `{wr, wstrb[3:0], idx, wdata}`;
  - the FSM state enum `{S_IDLE, S_BUSY}`;
  - the constant `SRAM_DATA_W = 32`.
- One sub-module, `sram_req_fifo`: a parameterised synchronous FIFO with push, pop, head, count, full and empty, and asynchronous reset.
- The array, strobe merge and FSM live in the top module.

## Test plan
- Write then read, LATENCY=2: write `0x0000_0040` with data `0xDEADBEEF` and `wstrb=1111`, then read the same address. Required: `data_ok` 2 cycles after each request is serviced, and the read returns `0xDEADBEEF`.
- Byte strobe: from `0xDEADBEEF`, write `0x11223344` with `wstrb=0101`, then read. Required: `0xDE22BE44`. Also write with `wstrb=0000`: `data_ok` still pulses and the word is unchanged.
- Full queue, QUEUE_DEPTH=2, LATENCY=3: hold `req` high for 4 reads.
  - Required: `addr_ok` is high on the first 2 cycles, then low until occupancy drops below 2.
  - `data_ok` pulses are exactly 3 cycles apart, with data in order.
- LATENCY=1 streaming: 8 consecutive reads with `req` held high. Required: `data_ok` pulses back-to-back, limited only by `addr_ok`, with correct data.
- Reset mid-operation: assert `reset` while 2 requests are outstanding, one of them a write.
  - Required: no `data_ok` during or after reset for those requests, and `addr_ok` is 0 during reset and 1 one cycle after release.
  - Words written before the reset keep their values, and the dropped write has no effect.
- Address aliasing: a read at `addr=0x0000_1043` with ADDR_WIDTH=10. Required: it returns word index 16, the same as `addr=0x0000_0040`.
